// File: rtl/round_judge.sv
// Quiz-round judge: arms on START, watches per-player answer codes, and
// registers the round outcome (winner, draw, all locked out, or timeout).
module round_judge #(
    parameter int NPLAYER = 2,
    parameter int TIMEOUT = 1000,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [2*NPLAYER-1:0]   ANS,
    input  logic                   ACK,
    output logic                   BUSY,
    output logic                   RESULT_VALID,
    output logic [1:0]             RESULT,
    output logic [NPLAYER-1:0]     WINNER,
    output logic [NPLAYER-1:0]     LOCKOUT,
    output logic [TW-1:0]          TIMER
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DONE
    } state_t;

    localparam logic [1:0] RES_TIMEOUT = 2'b00;
    localparam logic [1:0] RES_SINGLE  = 2'b01;
    localparam logic [1:0] RES_LOCKED  = 2'b10;
    localparam logic [1:0] RES_DRAW    = 2'b11;

    // The round ends on the edge where TIMER would step onto TIMEOUT.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t               state;
    logic [NPLAYER-1:0]   correct_v;
    logic [NPLAYER-1:0]   wrong_v;
    logic [NPLAYER-1:0]   lockout_next;
    logic                 multi_correct;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        correct_v = '0;
        wrong_v   = '0;
        for (int i = 0; i < NPLAYER; i++) begin
            if (!LOCKOUT[i]) begin
                correct_v[i] = (ANS[2*i +: 2] == 2'b01);
                wrong_v[i]   = (ANS[2*i +: 2] == 2'b10);
            end
        end
        lockout_next  = LOCKOUT | wrong_v;
        multi_correct = |(correct_v & (correct_v - NPLAYER'(1)));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            BUSY         <= 1'b0;
            RESULT_VALID <= 1'b0;
            RESULT       <= RES_TIMEOUT;
            WINNER       <= '0;
            LOCKOUT      <= '0;
            TIMER        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_ARMED;
                        BUSY    <= 1'b1;
                        RESULT  <= RES_TIMEOUT;
                        WINNER  <= '0;
                        LOCKOUT <= '0;
                        TIMER   <= '0;
                    end
                end

                S_ARMED: begin
                    LOCKOUT <= lockout_next;
                    if (|correct_v) begin
                        state        <= S_DONE;
                        BUSY         <= 1'b0;
                        RESULT_VALID <= 1'b1;
                        WINNER       <= correct_v;
                        RESULT       <= multi_correct ? RES_DRAW : RES_SINGLE;
                    end else if (&lockout_next) begin
                        state        <= S_DONE;
                        BUSY         <= 1'b0;
                        RESULT_VALID <= 1'b1;
                        WINNER       <= '0;
                        RESULT       <= RES_LOCKED;
                    end else begin
                        TIMER <= TIMER + TW'(1);
                        if (TIMER == TIMER_LAST) begin
                            state        <= S_DONE;
                            BUSY         <= 1'b0;
                            RESULT_VALID <= 1'b1;
                            WINNER       <= '0;
                            RESULT       <= RES_TIMEOUT;
                        end
                    end
                end

                S_DONE: begin
                    if (ACK) begin
                        state        <= S_IDLE;
                        RESULT_VALID <= 1'b0;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    BUSY         <= 1'b0;
                    RESULT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge: three instances (2, 4 and 3 players) share
// clock and reset; each scenario task checks packed output snapshots.
`timescale 1ns/1ps
module tb_round_judge;

    logic CLK;
    logic RST;

    // 2 players, TIMEOUT=5 (TW=3)
    logic       a_start, a_ack, a_busy, a_valid;
    logic [3:0] a_ans;
    logic [1:0] a_result, a_winner, a_lockout;
    logic [2:0] a_timer;

    // 4 players, default TIMEOUT=1000 (TW=10)
    logic       b_start, b_ack, b_busy, b_valid;
    logic [7:0] b_ans;
    logic [1:0] b_result;
    logic [3:0] b_winner, b_lockout;
    logic [9:0] b_timer;

    // 3 players, TIMEOUT=20 (TW=5)
    logic       c_start, c_ack, c_busy, c_valid;
    logic [5:0] c_ans;
    logic [1:0] c_result;
    logic [2:0] c_winner, c_lockout;
    logic [4:0] c_timer;

    int passed = 0;
    int total  = 0;

    round_judge #(.NPLAYER(2), .TIMEOUT(5)) u_a (
        .CLK(CLK), .RST(RST), .START(a_start), .ANS(a_ans), .ACK(a_ack),
        .BUSY(a_busy), .RESULT_VALID(a_valid), .RESULT(a_result),
        .WINNER(a_winner), .LOCKOUT(a_lockout), .TIMER(a_timer)
    );

    round_judge #(.NPLAYER(4)) u_b (
        .CLK(CLK), .RST(RST), .START(b_start), .ANS(b_ans), .ACK(b_ack),
        .BUSY(b_busy), .RESULT_VALID(b_valid), .RESULT(b_result),
        .WINNER(b_winner), .LOCKOUT(b_lockout), .TIMER(b_timer)
    );

    round_judge #(.NPLAYER(3), .TIMEOUT(20)) u_c (
        .CLK(CLK), .RST(RST), .START(c_start), .ANS(c_ans), .ACK(c_ack),
        .BUSY(c_busy), .RESULT_VALID(c_valid), .RESULT(c_result),
        .WINNER(c_winner), .LOCKOUT(c_lockout), .TIMER(c_timer)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Snapshot layout: {BUSY, RESULT_VALID, RESULT, WINNER, LOCKOUT, TIMER}
    function automatic logic [10:0] snap_a();
        return {a_busy, a_valid, a_result, a_winner, a_lockout, a_timer};
    endfunction

    function automatic logic [21:0] snap_b();
        return {b_busy, b_valid, b_result, b_winner, b_lockout, b_timer};
    endfunction

    function automatic logic [14:0] snap_c();
        return {c_busy, c_valid, c_result, c_winner, c_lockout, c_timer};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (snap_a() !== 11'd0) $display("FAIL reset_a got %h exp %h", snap_a(), 11'd0);
        else passed++;
        total++;
        if (snap_b() !== 22'd0) $display("FAIL reset_b got %h exp %h", snap_b(), 22'd0);
        else passed++;
        total++;
        if (snap_c() !== 15'd0) $display("FAIL reset_c got %h exp %h", snap_c(), 15'd0);
        else passed++;
    endtask

    task automatic test_single_winner();
        logic [10:0] exp;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0};
        total++;
        if (snap_a() !== exp) $display("FAIL armed got %h exp %h", snap_a(), exp);
        else passed++;
        repeat (3) tick();
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd3};
        total++;
        if (snap_a() !== exp) $display("FAIL count3 got %h exp %h", snap_a(), exp);
        else passed++;
        a_ans = 4'b0001;
        tick();
        a_ans = 4'b1000;   // ignored while DONE
        exp = {1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 3'd3};
        total++;
        if (snap_a() !== exp) $display("FAIL single_win got %h exp %h", snap_a(), exp);
        else passed++;
        tick();
        a_ans = 4'b0000;
        total++;
        if (snap_a() !== exp) $display("FAIL done_hold got %h exp %h", snap_a(), exp);
        else passed++;
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        exp = {1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'd3};
        total++;
        if (snap_a() !== exp) $display("FAIL idle_hold got %h exp %h", snap_a(), exp);
        else passed++;
    endtask

    task automatic test_lockout();
        logic [10:0] exp;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_ans = 4'b1000;   // player 1 wrong
        tick();
        a_ans = 4'b0100;   // player 1 correct, but locked out
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 3'd1};
        total++;
        if (snap_a() !== exp) $display("FAIL lock_p1 got %h exp %h", snap_a(), exp);
        else passed++;
        tick();
        a_ans = 4'b0001;   // player 0 correct
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 3'd2};
        total++;
        if (snap_a() !== exp) $display("FAIL ignore_locked got %h exp %h", snap_a(), exp);
        else passed++;
        tick();
        a_ans = 4'b0000;
        exp = {1'b0, 1'b1, 2'b01, 2'b01, 2'b10, 3'd2};
        total++;
        if (snap_a() !== exp) $display("FAIL win_after_lock got %h exp %h", snap_a(), exp);
        else passed++;
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
    endtask

    task automatic test_timeout();
        logic [10:0] exp;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_ack = 1'b1;      // ignored while ARMED
        tick();
        a_ack = 1'b0;
        repeat (3) tick();
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd4};
        total++;
        if (snap_a() !== exp) $display("FAIL pre_timeout got %h exp %h", snap_a(), exp);
        else passed++;
        tick();
        exp = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'd5};
        total++;
        if (snap_a() !== exp) $display("FAIL timeout got %h exp %h", snap_a(), exp);
        else passed++;
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        // correct answer on the timeout cycle wins
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (4) tick();
        a_ans = 4'b0100;
        tick();
        a_ans = 4'b0000;
        exp = {1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 3'd4};
        total++;
        if (snap_a() !== exp) $display("FAIL timeout_tie got %h exp %h", snap_a(), exp);
        else passed++;
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
    endtask

    task automatic test_ack_start();
        logic [10:0] exp;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_ans = 4'b0001;
        tick();
        a_ans = 4'b0000;
        a_ack = 1'b1;
        a_start = 1'b1;
        tick();
        a_ack = 1'b0;
        exp = {1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'd0};
        total++;
        if (snap_a() !== exp) $display("FAIL ack_start_idle got %h exp %h", snap_a(), exp);
        else passed++;
        tick();
        a_start = 1'b0;
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0};
        total++;
        if (snap_a() !== exp) $display("FAIL rearm got %h exp %h", snap_a(), exp);
        else passed++;
    endtask

    task automatic test_reset_midround();
        logic [10:0] exp;
        a_ans = 4'b0010;   // player 0 wrong
        tick();
        a_ans = 4'b0000;
        exp = {1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 3'd1};
        total++;
        if (snap_a() !== exp) $display("FAIL lock_p0 got %h exp %h", snap_a(), exp);
        else passed++;
        #2 RST = 1'b1;
        #1;
        total++;
        if (snap_a() !== 11'd0) $display("FAIL async_reset got %h exp %h", snap_a(), 11'd0);
        else passed++;
        #2 RST = 1'b0;
        tick();
        total++;
        if (snap_a() !== 11'd0) $display("FAIL post_reset got %h exp %h", snap_a(), 11'd0);
        else passed++;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_ans = 4'b0100;
        tick();
        a_ans = 4'b0000;
        exp = {1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 3'd0};
        total++;
        if (snap_a() !== exp) $display("FAIL post_reset_round got %h exp %h", snap_a(), exp);
        else passed++;
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
    endtask

    task automatic test_draw();
        logic [21:0] exp;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        b_ans = 8'b01_00_01_10;   // players 1,3 correct; player 0 wrong
        tick();
        b_ans = 8'b0;
        exp = {1'b0, 1'b1, 2'b11, 4'b1010, 4'b0001, 10'd1};
        total++;
        if (snap_b() !== exp) $display("FAIL draw got %h exp %h", snap_b(), exp);
        else passed++;
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
    endtask

    task automatic test_all_locked();
        logic [14:0] exp;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        c_ans = 6'b00_00_10;
        tick();
        c_ans = 6'b0;
        tick();
        c_ans = 6'b00_10_00;
        tick();
        c_ans = 6'b00_00_01;      // player 0 locked, ignored
        tick();
        exp = {1'b1, 1'b0, 2'b00, 3'b000, 3'b011, 5'd4};
        total++;
        if (snap_c() !== exp) $display("FAIL partial_lock got %h exp %h", snap_c(), exp);
        else passed++;
        c_ans = 6'b10_00_00;
        tick();
        c_ans = 6'b0;
        exp = {1'b0, 1'b1, 2'b10, 3'b000, 3'b111, 5'd4};
        total++;
        if (snap_c() !== exp) $display("FAIL all_locked got %h exp %h", snap_c(), exp);
        else passed++;
        c_ack = 1'b1;
        tick();
        c_ack = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        a_start = 1'b0; a_ack = 1'b0; a_ans = '0;
        b_start = 1'b0; b_ack = 1'b0; b_ans = '0;
        c_start = 1'b0; c_ack = 1'b0; c_ans = '0;
        #2;
        test_reset();
        #10 RST = 1'b0;
        tick();
        test_single_winner();
        test_lockout();
        test_timeout();
        test_ack_start();
        test_reset_midround();
        test_draw();
        test_all_locked();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
